mac_operand_feeder: RTL
=======================

Name: mac_operand_feeder

Overview:
Transmit-side front end for the 32x32 MAC unit. Buffers incoming operand pairs in a small FIFO, clears the MAC accumulator, then issues exactly vec_len pairs on the MAC's multiplicand/multiplier inputs, inserting zero pairs as bubbles. After the MAC pipeline drains, it captures the 65-bit accumulator as a dot-product result with a one-cycle valid pulse.

Parameters:
DEPTH, 8, operand-pair FIFO depth (power of 2, >=2)
LEN_W, 8, width of vec_len and the issue counter
MAC_LAT, 1, clock edges from operands leaving this block until accumulator_in reflects them

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO not full; pair accepted when in_valid && in_ready
in_a  input  32  multiplicand of offered pair
in_b  input  32  multiplier of offered pair
start  input  1  begin a dot product; sampled only in IDLE
vec_len  input  LEN_W  number of pairs to issue; latched on accepted start
busy  output  1  high in every state except IDLE
mac_clr  output  1  one-cycle active-high accumulator clear to the MAC
multiplicand  output  32  registered operand to MAC
multiplier  output  32  registered operand to MAC
accumulator_in  input  65  MAC accumulator_out
result  output  65  captured dot product; holds until next capture
result_valid  output  1  one-cycle pulse when result updates
done  output  1  same-cycle copy of result_valid

Behaviour:
- Reset (reset=0, async): FSM=IDLE, FIFO empty, counter=0, multiplicand=multiplier=0, mac_clr=0, result=0, result_valid=done=0, busy=0, in_ready=1 after release.
- FIFO: push on in_valid && in_ready; pop only in ISSUE when not empty. in_ready = !full. Simultaneous push+pop when full is not allowed (full gates in_ready); simultaneous push+pop when non-full keeps count unchanged. Pointers wrap modulo DEPTH. FIFO accepts pushes in every state, including IDLE.
- FSM states:
  IDLE: multiplicand/multiplier=0. Accepting start latches vec_len, sets counter=0, goes to CLEAR.
  CLEAR: mac_clr=1 for exactly this cycle; operands=0. Next state ISSUE if latched len>0, else DRAIN.
  ISSUE: if FIFO non-empty, pop head into multiplicand/multiplier and increment counter. If empty, drive 0/0 as a bubble and leave the counter unchanged. When the pop makes counter==len, the next state is DRAIN.
  DRAIN: operands=0; wait MAC_LAT+1 cycles using a drain counter. On the last DRAIN cycle, result<=accumulator_in, result_valid=done=1 on the following cycle; go to IDLE.
- Operand registers update only as stated above. Zero pairs contribute 0 to the MAC sum.
- Width: result is the full 65 bits, with no truncation or saturation; the MAC owns overflow behaviour.
- start while busy is ignored. in_valid with no start only fills the FIFO. Pairs beyond len remain queued for the next run.
- Reset mid-operation: immediately returns to reset state. The FIFO contents are discarded and result is cleared.

Test Plan:
- Basic: push (2,3),(4,5),(6,7); start vec_len=3 -> mac_clr pulse once, three consecutive issue cycles, result=68, single result_valid, busy low next cycle.
- Bubbles: start vec_len=2 with an empty FIFO; push (0x11111111,0x11111111) then 3 idle cycles later push (1,1) -> zero operands during the gap, result=0x0123456787654321+1, counter never advances on bubbles.
- Zero length: start vec_len=0 -> CLEAR then DRAIN, result=0, result_valid pulse; the FIFO is untouched.
- Full FIFO: push DEPTH pairs of (1,1) with no start -> in_ready=0 after the 8th push and a 9th offer is not accepted; start vec_len=8 -> result=8, in_ready returns high after the first pop.
- Large operands: (0x12345678,0x87654321) plus (0xFFFFFFFF,0xFFFFFFFF), vec_len=2 -> result=0x09A0CD0570B88D78+0xFFFFFFFE00000001 exact in 65 bits; start asserted during DRAIN is ignored.
- Async reset asserted mid-ISSUE between clock edges -> all outputs 0 immediately and in_ready=1 after release. A fresh run with (3,3), vec_len=1 yields result=9.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Transmit-side front end for the 32x32 MAC. Operand pairs are buffered in a
//   small FIFO. A run clears the MAC accumulator, issues exactly vec_len pairs
//   (zero pairs fill any gap while the FIFO is empty), waits for the MAC
//   pipeline to drain, then captures the 65-bit accumulator as the result.
//
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   in_valid/in_ready   operand-pair handshake into the FIFO (in_a, in_b)
//   start, vec_len      begin a run of vec_len pairs (sampled only in IDLE)
//   busy                high whenever a run is in progress
//   mac_clr             one-cycle accumulator clear to the MAC
//   multiplicand,
//   multiplier          registered operands to the MAC
//   accumulator_in      MAC accumulator output
//   result,
//   result_valid, done  captured dot product and its one-cycle pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, operands held at zero
// CLEAR | mac_clr asserted for this single cycle
// ISSUE | pop one pair per cycle when available, else issue a bubble
// DRAIN | wait MAC_LAT+1 cycles, capture accumulator on the last one

module mac_operand_feeder #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  output logic             mac_clr,
  output logic [31:0]      multiplicand,
  output logic [31:0]      multiplier,
  input  logic [64:0]      accumulator_in,
  output logic [64:0]      result,
  output logic             result_valid,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough to hold MAC_LAT, and at least one bit even when MAC_LAT is 0.
  localparam int DW = $clog2(MAC_LAT + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0]  DRAIN_LD  = DW'(MAC_LAT);

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] issue_nxt;
  logic [DW-1:0]    drain_cnt;

  logic [31:0]      mem_a [DEPTH];
  logic [31:0]      mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == ST_ISSUE) && !empty;
  assign issue_nxt = issue_cnt + LEN_W'(1);

  assign busy    = (state != ST_IDLE);
  assign mac_clr = (state == ST_CLEAR);
  assign done    = result_valid;

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Operands are nonzero only in the cycle after a pop; everything else is a
  // zero pair, which adds nothing to the MAC sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (pop) begin
      multiplicand <= mem_a[rd_ptr];
      multiplier   <= mem_b[rd_ptr];
    end else begin
      multiplicand <= '0;
      multiplier   <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      issue_cnt    <= '0;
      drain_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= vec_len;
            issue_cnt <= '0;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (len_q != '0) begin
            state <= ST_ISSUE;
          end else begin
            drain_cnt <= DRAIN_LD;
            state     <= ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          if (pop) begin
            issue_cnt <= issue_nxt;
            if (issue_nxt == len_q) begin
              drain_cnt <= DRAIN_LD;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Terminal count: the last operand pair has reached the accumulator.
          if (drain_cnt == '0) begin
            result       <= accumulator_in;
            result_valid <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
